// File: rtl/tinyalu_param.sv
`default_nettype none
// ============================================================================
// Module      : tinyalu_param
// Description : Parameterised tiny ALU. Single-cycle ops and a multi-cycle
//               pipelined multiplier share one start/ready/done interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tinyalu_param #(
    parameter int WIDTH       = 8,
    parameter int MULT_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           op,
    input  logic                 start,
    output logic                 ready,
    output logic                 done,
    output logic                 err,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = $clog2(MULT_STAGES + 1);
    localparam int SH_W  = $clog2(WIDTH) + 1;

    localparam logic [2:0] c_OP_NOP = 3'b000;
    localparam logic [2:0] c_OP_ADD = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_MUL = 3'b100;
    localparam logic [2:0] c_OP_SUB = 3'b101;
    localparam logic [2:0] c_OP_SHL = 3'b110;
    localparam logic [2:0] c_OP_ILL = 3'b111;

    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MULT_STAGES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic               w_accept;
    logic               w_mul_multi;
    logic [2*WIDTH-1:0] w_a2, w_b2;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_sub;
    logic [SH_W-1:0]    w_shamt;
    logic [2*WIDTH-1:0] w_alu;
    logic [2*WIDTH-1:0] w_mul_out;

    assign ready       = (cnt_q == '0);
    assign w_accept    = start && ready;
    assign w_mul_multi = (op == c_OP_MUL) && (MULT_STAGES > 1);

    assign w_a2    = {{WIDTH{1'b0}}, A};
    assign w_b2    = {{WIDTH{1'b0}}, B};
    assign w_prod  = w_a2 * w_b2;
    // Bit WIDTH of the widened difference is the borrow.
    assign w_sub   = {1'b0, A} - {1'b0, B};
    assign w_shamt = B[SH_W-1:0];

    always_comb begin
        w_alu = '0;
        case (op)
            c_OP_ADD: w_alu = w_a2 + w_b2;
            c_OP_AND: w_alu = w_a2 & w_b2;
            c_OP_XOR: w_alu = w_a2 ^ w_b2;
            c_OP_MUL: w_alu = w_prod;
            c_OP_SUB: w_alu = {{(WIDTH-1){1'b0}}, w_sub};
            c_OP_SHL: w_alu = w_a2 << w_shamt;
            default:  w_alu = '0;
        endcase
    end

    generate
        if (MULT_STAGES > 1) begin : g_mul_pipe
            logic [2*WIDTH-1:0] pipe_q [MULT_STAGES-1];

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int i = 0; i < MULT_STAGES - 1; i++) pipe_q[i] <= '0;
                end else begin
                    if (w_accept && w_mul_multi) pipe_q[0] <= w_prod;
                    for (int i = 1; i < MULT_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign w_mul_out = pipe_q[MULT_STAGES-2];
        end else begin : g_mul_direct
            assign w_mul_out = w_prod;
        end
    endgenerate

    // Accept is only possible with the counter at zero, so the two branches are exclusive.
    always_comb begin
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        result_d = result_q;
        if (w_accept) begin
            if (w_mul_multi) begin
                cnt_d = c_CNT_LOAD;
            end else if (op != c_OP_NOP) begin
                done_d   = 1'b1;
                err_d    = (op == c_OP_ILL);
                result_d = w_alu;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - c_CNT_ONE;
            if (cnt_q == c_CNT_ONE) begin
                done_d   = 1'b1;
                result_d = w_mul_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;

endmodule
`default_nettype wire

// File: doc/tinyalu_param.md
Name: tinyalu_param

Overview:
- Parametrised successor to the team's fixed 8-bit tiny ALU: configurable operand width, configurable multiplier pipeline depth, extended op set, and an explicit ready/busy handshake.
- Single-cycle ops and a multi-cycle multiplier share one start/done interface. Illegal opcodes are flagged with an error bit.
- Sits as a leaf datapath block driven by a bus-functional driver or a CPU-style sequencer in the test environments.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 2..32.
- MULT_STAGES, 3, multiplier latency in cycles from accepted start to done. Legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset, sampled on posedge clk.
- A  input  WIDTH  operand A, sampled when start is accepted.
- B  input  WIDTH  operand B, sampled when start is accepted.
- op  input  3  opcode, sampled when start is accepted.
- start  input  1  request strobe. Accepted only when ready=1.
- ready  output  1  block can accept start this cycle.
- done  output  1  one-cycle pulse: result and err are valid.
- err  output  1  valid with done. 1 means illegal opcode.
- result  output  2*WIDTH  operation result, held between done pulses.

Behaviour:
- Reset (reset_n=0 at a posedge):
  - done=0, err=0, result=0, ready=1.
  - Multiplier pipeline and cycle counter are cleared.
  - Reset mid-multiply discards the operation; no done is ever produced for it.
- Accept: start=1 and ready=1 at a posedge. A, B and op are captured at that edge. start while ready=0 is ignored: no capture, no queueing, no done.
- Opcodes (results zero-extended to 2*WIDTH unless stated):
  - 000 NOP: accepted, but no done and no result update (matches legacy behaviour).
  - 001 ADD: A+B, WIDTH+1 bits; the carry lands in bit WIDTH.
  - 010 AND: A&B.
  - 011 XOR: A^B.
  - 100 MUL: A*B, full 2*WIDTH bits, unsigned.
  - 101 SUB: A-B, modulo 2^WIDTH in bits [WIDTH-1:0]. Bit WIDTH = borrow (1 when A<B). Upper bits are 0.
  - 110 SHL: A << B[$clog2(WIDTH):0], result 2*WIDTH bits. Shift amounts >= 2*WIDTH give 0.
  - 111 illegal: done=1, err=1, result=0, latency 1.
- Latency, with start accepted at edge N:
  - Single-cycle ops (001, 010, 011, 101, 110, 111): done=1 after edge N+1.
  - MUL: done=1 after edge N+MULT_STAGES.
- ready:
  - Single-cycle ops never drop ready, so back-to-back starts produce one done per cycle.
  - MUL with MULT_STAGES>1: ready=0 from after edge N until the cycle done is high. ready=1 in the done cycle, so a new start can be accepted in that same cycle (zero bubble).
  - MUL with MULT_STAGES=1: ready never drops; MUL behaves like a single-cycle op.
- Busy tracking: a down-counter loaded with MULT_STAGES-1 on MUL accept, decremented each cycle. Done fires when it reaches 0.
- done and err are high for exactly one cycle per accepted non-NOP op. err=0 on every legal op.
- result updates only on the edge that raises done, then holds until the next done or reset.
- Simultaneous events: reset_n=0 overrides start and any in-flight operation.

Test Plan (WIDTH=8, MULT_STAGES=3 unless noted):
- Reset then idle: reset_n=0 for 2 cycles, then 1 → result=0, done=0, err=0, ready=1.
- ADD carry: A=8'hFF, B=8'h01, op=001 → done next cycle, result=16'h0100, err=0. Back-to-back AND then XOR with A=8'hF0, B=8'h3C → consecutive done pulses with results 16'h0030 and 16'h00CC.
- SUB borrow: A=8'h05, B=8'h07, op=101 → result=16'h01FE.
- MUL latency and busy:
  - A=8'hFF, B=8'hFF, op=100 → ready=0 for 2 cycles, then done with result=16'hFE01 exactly 3 cycles after accept.
  - start asserted while busy (ADD 1+1) → ignored, no extra done.
  - Repeat with MULT_STAGES=1 → done after 1 cycle, ready never drops.
- MUL followed by zero-bubble start: issue ADD 2+3 in the MUL done cycle → accepted; done next cycle with result=16'h0005. result holds at 16'hFE01 between the two pulses.
- Illegal, NOP and mid-op reset:
  - op=111 → done=1, err=1, result=0.
  - op=000 with start → no done, result unchanged.
  - reset_n=0 one cycle after a MUL accept → no done afterwards, result=0, ready=1.
